window_gen_kxk: RTL
===================

# window_gen_kxk

Parametrised K×K sliding-window generator for the convolution datapath, succeeding the fixed 3×3 line buffer. It accepts a raster-order pixel stream, stores K-1 previous image rows, and emits a full K×K window on a flattened bus. Compared with the fixed 3×3 block it adds configurable kernel size and stride, image-height tracking with end-of-frame marking, start-of-frame resynchronisation, and ready/valid backpressure on both sides. It sits between the pixel source and the MAC array.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits (signed two's complement, passed through unmodified)
- IMG_W, 32, pixels per row; must be ≥ K
- IMG_H, 32, rows per frame; must be ≥ K
- K, 3, kernel size; range 2..7
- STRIDE, 1, horizontal and vertical window stride; range 1..K

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, asynchronous and active-high; one clock domain only
- in_valid  in  1  pixel_in is valid
- in_ready  out  1  block accepts a pixel this cycle
- in_sof  in  1  qualifies the accepted pixel as row 0, column 0 of a new frame
- pixel_in  in  DATA_W  input pixel
- out_valid  out  1  win_out is valid
- out_ready  in  1  consumer accepts the window
- out_last  out  1  valid with out_valid; marks the last window of the frame
- win_out  out  K*K*DATA_W  window; element (r,c) occupies bits [(r*K+c)*DATA_W +: DATA_W]; r=0 is the oldest (top) row, c=0 is the leftmost column; element (K-1,K-1) is the most recently accepted pixel

## Operation
- Accept occurs when in_valid && in_ready. Only an accept advances state.
- col_cnt runs 0..IMG_W-1 and wraps to 0 with row_cnt++. row_cnt runs 0..IMG_H-1 and wraps to 0 at end of frame.
- An accept with in_sof=1 forces that pixel to (0,0) and clears the stride phases. The line buffers are not cleared, because rows 0..K-2 never produce windows. An in_sof on a pixel already at (0,0) has no extra effect.
- Line storage: K-1 delay lines of IMG_W entries each. On every accept, line i shifts in the output of line i-1; line 0 takes pixel_in.
- Window register: K rows × K columns. On every accept each row shifts left by one column; the new column is {line K-2 out, …, line 0 out, pixel_in}.
- Emit condition: col_cnt ≥ K-1, row_cnt ≥ K-1, col phase = 0 and row phase = 0.
  - Phase counters wrap at STRIDE.
  - The col phase starts counting at col K-1 of each row; the row phase starts counting at row K-1.
- Windows per frame: ((IMG_W-K)/STRIDE+1) × ((IMG_H-K)/STRIDE+1).
- out_last is set on the window emitted at the last emit position of the frame.
- Column wrap: a window never spans two rows, because windows are suppressed while col_cnt < K-1 after a wrap.
- Backpressure: in_ready = !out_valid || out_ready.
  - The output register holds win_out, out_valid and out_last stable until out_ready.
  - Simultaneous consume and new emit on the same cycle loads the new window with no gap.
- Reset values: out_valid=0, out_last=0, win_out=0, col_cnt=row_cnt=0, phases=0, line buffers=0. in_ready=1 immediately after reset.
- Reset mid-frame: all state is discarded, and the next accepted pixel is (0,0) whether or not in_sof is asserted.

## Timing
- Latency: out_valid rises on the cycle after the accept of the pixel that completes the window (one register stage).
- Throughput: one pixel per cycle, and one window per cycle at most, with out_ready held high.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from in_valid to out_valid.
- in_valid low holds all state, including a pending window.

## Structure
- Shared package window_pkg holds:
  - the counter-width helper function (clog2-based);
  - localparams for the window-count formula;
  - the element-index macro/function (r*K+c), used by the MAC array.
- One sub-module, line_delay (parametrised DATA_W and depth IMG_W, enable = accept), instantiated K-1 times with a generate loop. It is register-based; an inferred RAM is acceptable for IMG_W ≥ 64.

## Test plan
- K=3, IMG_W=4, IMG_H=4, STRIDE=1, pixels 1..16 with out_ready=1 → exactly 4 windows:
  - first window is 1,2,3 / 5,6,7 / 9,10,11, one cycle after pixel 11 is accepted;
  - the next windows end at pixels 12, 15 and 16;
  - out_last is high only on the window ending at 16.
- K=3, IMG_W=5, IMG_H=5, STRIDE=2, pixels 1..25 → 4 windows ending at pixels 13, 15, 23 and 25; out_last is high on the window ending at 25.
- Same stream as the first test with out_ready low for 3 cycles while the window ending at 11 is valid:
  - in_ready is low for those cycles;
  - win_out stays stable;
  - no pixel is lost;
  - the window sequence is identical to the first test.
- Send 6 pixels of a frame, then in_sof with pixels 1..16 → output is identical to the first test (stale rows never emitted).
- Assert rst asynchronously mid-frame, off a clock edge, while out_valid=1:
  - out_valid and win_out go to 0 immediately;
  - then pixels 1..16 reproduce the first test.
- K=5, IMG_W=6, IMG_H=5, STRIDE=1, pixels 1..30 → 2 windows; the first has top row 1..5 and bottom row 25..29.

Source files
------------

// File: rtl/window_pkg.sv
// Shared helpers for the K x K window generator: counter sizing, window-count
// arithmetic and the flattened window element index used by the MAC array.
package window_pkg;

    localparam int K_MIN = 2;
    localparam int K_MAX = 7;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Windows along one dimension of a frame.
    function automatic int win_per_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    // Coordinate of the last emit position along one dimension.
    function automatic int last_emit(input int img, input int k, input int s);
        return (k - 1) + ((img - k) / s) * s;
    endfunction

    function automatic int elem_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/window_gen_kxk_line_delay.sv
// One image row of pixel delay: the output is the pixel accepted exactly DEPTH
// enables earlier, i.e. the same column one row up.
module line_delay #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator: raster pixel stream in, one registered
// window per emit position out, with stride, end-of-frame and backpressure.
module window_gen_kxk
    import window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_W-1:0]     pixel_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [K*K*DATA_W-1:0] win_out
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int PW = cnt_w(STRIDE);
    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(last_emit(IMG_W, K, STRIDE));
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(last_emit(IMG_H, K, STRIDE));
    localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [PW-1:0] col_ph_q, col_ph_d, cur_col_ph;
    logic [PW-1:0] row_ph_q, row_ph_d, cur_row_ph;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          accept, emit, is_last;

    logic [DATA_W-1:0] win_q [K][K];
    logic [DATA_W-1:0] win_d [K][K];
    logic [DATA_W-1:0] line_out [K-1];

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < K-1; i++) begin : g_line
        logic [DATA_W-1:0] line_in;
        if (i == 0) begin : g_first
            assign line_in = pixel_in;
        end else begin : g_chain
            assign line_in = line_out[i-1];
        end
        line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (line_in),
            .dout (line_out[i])
        );
    end

    // in_sof relocates the pixel being accepted to (0,0) with zero phases.
    always_comb begin
        cur_col    = in_sof ? '0 : col_q;
        cur_row    = in_sof ? '0 : row_q;
        cur_col_ph = in_sof ? '0 : col_ph_q;
        cur_row_ph = in_sof ? '0 : row_ph_q;
        emit    = (cur_col >= COL_FIRST) && (cur_row >= ROW_FIRST) &&
                  (cur_col_ph == '0) && (cur_row_ph == '0);
        is_last = emit && (cur_col == COL_LAST) && (cur_row == ROW_LAST);

        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        if (accept) begin
            row_d    = cur_row;
            row_ph_d = cur_row_ph;
            if (cur_col == COL_MAX) begin
                col_d    = '0;
                col_ph_d = '0;
                if (cur_row == ROW_MAX) begin
                    row_d    = '0;
                    row_ph_d = '0;
                end else begin
                    row_d    = cur_row + RW'(1);
                    row_ph_d = (cur_row < ROW_FIRST || cur_row_ph == PH_MAX) ?
                               '0 : cur_row_ph + PW'(1);
                end
            end else begin
                col_d    = cur_col + CW'(1);
                col_ph_d = (cur_col < COL_FIRST || cur_col_ph == PH_MAX) ?
                           '0 : cur_col_ph + PW'(1);
            end
        end
    end

    // The window register doubles as the output data register: it only moves
    // on an accept, and no accept happens while a window is stalled.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < K-1; r++) begin
                win_d[r][K-1] = line_out[K-2-r];
            end
            win_d[K-1][K-1] = pixel_in;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = emit;
            out_last_d  = is_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            col_ph_q    <= '0;
            row_ph_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            col_ph_q    <= col_ph_d;
            row_ph_q    <= row_ph_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        win_out = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_out[elem_idx(r, c, K)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
